muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multi-cycle sequencer for RV32M MUL/DIV/REM ops, beside the single-cycle ALU in the execute stage.
- Operands in with a valid/ready handshake; an FSM runs a shift-add multiplier or restoring divider over XLEN cycles.
- Signed operands go through a sign pre-/post-correction step.
- The pipeline stalls on !in_ready and captures the result on the out_valid/out_ready handshake.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 4 and a power of two.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill any in-flight op; no result produced
- in_valid  in  1  operands/op valid
- in_ready  out  1  sequencer idle, can accept
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- result  out  XLEN  final result

Behaviour:
- Reset (reset_n low, async): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all internal accumulators 0.
- States and transitions:
  - IDLE → CALC on in_valid & in_ready & !flush.
  - IDLE → DONE on the divide-by-zero fast path.
  - CALC → FIX after XLEN iterations.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
  - Any state → IDLE on flush.
- in_ready = (state==IDLE). Acceptance at edge E0 latches op, a, b, the operand sign flags and |a|, |b|.
- Sign rules:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitude of the most negative value is 2^(XLEN-1), held as an unsigned value.
- CALC: one iteration per cycle, counter 0..XLEN-1.
  - Multiply: 2*XLEN-bit product; add multiplicand if multiplier LSB set, then shift.
  - Divide: restoring; shift remainder left, subtract divisor, keep if non-negative, set quotient bit.
- FIX (1 cycle):
  - Product: negate if the sign flags differ (signed cases only).
  - Quotient: negate if sa^sb.
  - Remainder: takes the sign of a.
  - Output selection: MUL → product[XLEN-1:0]; MULH* → product[2XLEN-1:XLEN].
- Latency: out_valid rises XLEN+2 cycles after the E0 edge (34 for XLEN=32).
  - result is registered and stable while out_valid is high.
  - out_valid falls the edge after out_ready is sampled high in DONE.
- Divide by zero (DIV/DIVU/REM/REMU, b==0), bypasses CALC:
  - Quotient = all ones; remainder = a.
  - out_valid 1 cycle after acceptance.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
  - Quotient = 0x80000000, remainder = 0.
  - Falls out of the magnitude algorithm; normal latency.
- in_valid while busy: ignored; the upstream holds its values. No new accept in the same cycle as DONE→IDLE.
- flush:
  - In any state: next state IDLE, out_valid=0, partial results discarded.
  - flush & in_valid in IDLE: not accepted.
  - flush has priority over out_ready.

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: a multiply op with a==0 or b==0 skips CALC/FIX; result 0, out_valid 1 cycle after acceptance.
- Undefined: all multiplies take the full XLEN+2 latency.
- Division is unaffected either way.

Decomposition:
- Package muldiv_pkg:
  - op encoding localparams (OP_MUL..OP_REMU).
  - FSM state encoding (IDLE, CALC, FIX, DONE).
  - Helper function is_div(op).
- One natural sub-module, muldiv_signfix: combinational abs/conditional-negate of a value given a sign flag. Used at input and in FIX.

Test Plan:
- MUL a=7 b=6 → result 0x0000002A; out_valid exactly 34 cycles after accept; in_ready low throughout.
- MULH a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU a=-1 b=2 → 0xFFFFFFFF.
- DIV a=-7 b=2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU a=0x80000000 b=0xFFFFFFFF → 0; DIV overflow case → 0x80000000, REM → 0.
- DIVU a=5 b=0 → 0xFFFFFFFF, REMU → 5; out_valid 1 cycle after accept.
- Hold out_ready=0 for 10 cycles in DONE → result/out_valid stable, in_ready=0; then out_ready=1 → IDLE next edge.
- Reset/flush/zero-skip:
  - Assert flush (or reset_n=0) at counter=15 → IDLE, no out_valid.
  - Next op MUL 3*3 → 9 with correct latency.
  - With MULDIV_ZERO_SKIP_EN, MUL 0*5 → 0 in 1 cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic a_signed(input logic [2:0] op);
      return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return a_signed(op) && (op != OP_MULHSU);
   endfunction

   // Result comes from the upper half for MULH* and REM*, lower half otherwise
   function automatic logic result_hi(input logic [2:0] op);
      return is_div(op) ? op[1] : (op[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate (abs when neg = sign bit).
module muldiv_signfix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] out_c
);

   assign out_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIV/REM sequencer: shift-add multiply, restoring divide.
// Optional MULDIV_ZERO_SKIP_EN: multiplies with a zero operand finish without CALC/FIX.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned PW = 2 * XLEN;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            sa_q, sa_d, sb_q, sb_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            sa_in_c, sb_in_c;
   logic [XLEN-1:0] abs_a_c, abs_b_c, quo_fix_c, rem_fix_c;
   logic [PW-1:0]   prod_fix_c, mul_next_c, div_next_c;
   logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;

   assign sa_in_c = a[XLEN-1] & a_signed(op);
   assign sb_in_c = b[XLEN-1] & b_signed(op);

   muldiv_signfix #(.W(XLEN)) u_abs_a (.val(a), .neg(sa_in_c), .out_c(abs_a_c));
   muldiv_signfix #(.W(XLEN)) u_abs_b (.val(b), .neg(sb_in_c), .out_c(abs_b_c));
   muldiv_signfix #(.W(PW))   u_fix_p (.val(prod_q), .neg(sa_q ^ sb_q), .out_c(prod_fix_c));
   muldiv_signfix #(.W(XLEN)) u_fix_q (.val(prod_q[XLEN-1:0]), .neg(sa_q ^ sb_q), .out_c(quo_fix_c));
   muldiv_signfix #(.W(XLEN)) u_fix_r (.val(prod_q[PW-1:XLEN]), .neg(sa_q), .out_c(rem_fix_c));

   // prod_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign mul_sum_c   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next_c  = {mul_sum_c, prod_q[XLEN-1:1]};
   assign div_shift_c = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
   assign div_diff_c  = div_shift_c - {1'b0, mcand_q};
   assign div_next_c  = div_diff_c[XLEN]
                      ? {div_shift_c[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                      : {div_diff_c[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      prod_d      = prod_q;
      mcand_d     = mcand_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;

      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               op_d  = op;
               sa_d  = sa_in_c;
               sb_d  = sb_in_c;
               cnt_d = '0;
               if (is_div(op)) begin
                  if (b == '0) begin
                     prod_d  = {a, {XLEN{1'b1}}};
                     state_d = DONE;
                  end else begin
                     prod_d  = {{XLEN{1'b0}}, abs_a_c};
                     mcand_d = abs_b_c;
                     state_d = CALC;
                  end
               end else begin
                  prod_d  = {{XLEN{1'b0}}, abs_b_c};
                  mcand_d = abs_a_c;
                  state_d = CALC;
`ifdef MULDIV_ZERO_SKIP_EN
                  if (a == '0 || b == '0) begin
                     prod_d  = '0;
                     state_d = DONE;
                  end
`endif
               end
            end
         end
         CALC: begin
            prod_d = is_div(op_q) ? div_next_c : mul_next_c;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            prod_d  = is_div(op_q) ? {rem_fix_c, quo_fix_c} : prod_fix_c;
            state_d = DONE;
         end
         DONE: begin
            // First DONE cycle registers the result; afterwards wait for the consumer
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               result_d    = result_hi(op_q) ? prod_q[PW-1:XLEN] : prod_q[XLEN-1:0];
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d     = IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         prod_q      <= '0;
         mcand_q     <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         prod_q      <= prod_d;
         mcand_q     <= mcand_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq plus flush/reset/hold sequences.
module tb_muldiv_seq;

   localparam int XLEN = 32;
`ifdef MULDIV_ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 34;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic            clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] a, b, result;

   int checks = 0;
   int errors = 0;
   logic busy_bad;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      op = o; a = va; b = vb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      busy_bad = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1; lat++;
         if (out_valid) break;
         if (in_ready) busy_bad = 1'b1;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t vecs[16];

   initial begin
      int lat;
      logic seen, hold_ok;

      vecs[0]  = '{3'b000, 32'd7,        32'd6,        32'h0000002A, 34};
      vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
      vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
      vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
      vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
      vecs[6]  = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
      vecs[7]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
      vecs[8]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
      vecs[9]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[10] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
      vecs[11] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1};
      vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34};
      vecs[13] = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
      vecs[14] = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
      vecs[15] = '{3'b000, 32'd0,        32'd5,        32'd0,        ZLAT};

      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 3'b000; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_valid(lat);
         chk($sformatf("v%0d_result", i), result, vecs[i].exp);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_busy", i), 32'(busy_bad), 32'd0);
         take();
      end

      // Hold the result in DONE while out_ready stays low
      start_op(3'b000, 32'd7, 32'd6);
      wait_valid(lat);
      chk("hold_first", result, 32'h2A);
      hold_ok = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (!out_valid || in_ready || result !== 32'h2A) hold_ok = 1'b0;
      end
      chk("hold_stable", 32'(hold_ok), 32'd1);
      take();
      chk("take_out_valid", 32'(out_valid), 32'd0);
      chk("take_in_ready", 32'(in_ready), 32'd1);

      // Flush at counter 15
      start_op(3'b000, 32'd7, 32'd6);
      repeat (15) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", 32'(seen), 32'd0);

      // flush together with in_valid in IDLE must not accept
      op = 3'b000; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_noaccept", 32'(in_ready), 32'd1);
      start_op(3'b000, 32'd3, 32'd3);
      wait_valid(lat);
      chk("post_flush_result", result, 32'd9);
      chk("post_flush_latency", 32'(lat), 32'd34);
      take();

      // Asynchronous reset at counter 15
      start_op(3'b000, 32'd7, 32'd6);
      repeat (15) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_result", result, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("arst_no_result", 32'(seen), 32'd0);
      start_op(3'b000, 32'd3, 32'd3);
      wait_valid(lat);
      chk("post_rst_result", result, 32'd9);
      chk("post_rst_latency", 32'(lat), 32'd34);
      take();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
